// File: rtl/key_cmd_pkg.sv
// Shared keycodes and controller state for the key-to-move-command path.
// The game logic imports the same keycode constants.
package key_cmd_pkg;

   localparam logic [7:0] KEY_NONE  = 8'h00;
   localparam logic [7:0] KEY_LEFT  = 8'h04;
   localparam logic [7:0] KEY_RIGHT = 8'h07;
   localparam logic [7:0] KEY_DROP  = 8'h16;
   localparam logic [7:0] KEY_ROT   = 8'h1A;

   typedef enum logic [1:0] {
      StIdle,
      StDas,
      StRepeat,
      StHold
   } key_state_e;

   // Maps any keycode the game does not use onto KEY_NONE.
   function automatic logic [7:0] key_filter(input logic [7:0] code);
      logic [7:0] res;
      case (code)
         KEY_LEFT, KEY_RIGHT, KEY_DROP, KEY_ROT: res = code;
         default:                                res = KEY_NONE;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/key_repeat_ctrl.sv
// Turns a held USB keycode into discrete move commands with DAS/ARR auto-repeat,
// presented one at a time through a valid/ack handshake.
module key_repeat_ctrl
   import key_cmd_pkg::*;
#(
   parameter int unsigned DAS_FRAMES = 10,
   parameter int unsigned ARR_FRAMES = 3
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic [7:0] keycode,
   input  logic       cmd_ack,
   output logic       cmd_valid,
   output logic [7:0] cmd_keycode
);

   localparam logic [7:0] DasLast = 8'(DAS_FRAMES - 1);
   localparam logic [7:0] ArrLast = 8'(ARR_FRAMES - 1);

   key_state_e state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] key_prev_q, key_prev_d;
   logic       cmd_valid_q, cmd_valid_d;
   logic [7:0] cmd_keycode_q, cmd_keycode_d;

   logic [7:0] key_cur;
   logic       press;
   logic       rpt;

   always_comb begin
      key_cur       = key_filter(keycode);
      state_d       = state_q;
      cnt_d         = cnt_q;
      key_prev_d    = key_cur;
      press         = 1'b0;
      rpt           = 1'b0;
      cmd_valid_d   = cmd_valid_q;
      cmd_keycode_d = cmd_keycode_q;

      if (key_cur == KEY_NONE) begin
         state_d = StIdle;
         cnt_d   = 8'd0;
      end else if (key_cur != key_prev_q) begin
         press = 1'b1;
         cnt_d = 8'd0;
         case (key_cur)
            KEY_LEFT, KEY_RIGHT: state_d = StDas;
            KEY_DROP:            state_d = StRepeat;
            default:             state_d = StHold;
         endcase
      end else begin
         unique case (state_q)
            StDas: begin
               if (cnt_q == DasLast) begin
                  rpt     = 1'b1;
                  cnt_d   = 8'd0;
                  state_d = StRepeat;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            StRepeat: begin
               if (cnt_q == ArrLast) begin
                  rpt   = 1'b1;
                  cnt_d = 8'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
            StIdle, StHold: ;
         endcase
      end

      // A press always overwrites; a repeat only lands if the slot is free or being freed.
      if (press || (rpt && (!cmd_valid_q || cmd_ack))) begin
         cmd_valid_d   = 1'b1;
         cmd_keycode_d = key_cur;
      end else if (cmd_ack) begin
         cmd_valid_d = 1'b0;
      end
   end

   always_ff @(posedge frame_clk) begin
      if (Reset) begin
         state_q       <= StIdle;
         cnt_q         <= 8'd0;
         key_prev_q    <= KEY_NONE;
         cmd_valid_q   <= 1'b0;
         cmd_keycode_q <= KEY_NONE;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         key_prev_q    <= key_prev_d;
         cmd_valid_q   <= cmd_valid_d;
         cmd_keycode_q <= cmd_keycode_d;
      end
   end

   assign cmd_valid   = cmd_valid_q;
   assign cmd_keycode = cmd_keycode_q;

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Directed bench for key_repeat_ctrl: DAS/ARR timing, one-shot rotate, drop/ack rules, reset.
module tb_key_repeat_ctrl;

   logic       frame_clk = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] keycode = 8'h00;
   logic       cmd_ack = 1'b0;
   logic       cmd_valid;
   logic [7:0] cmd_keycode;

   int tests_run = 0;
   int tests_failed = 0;

   key_repeat_ctrl #(
      .DAS_FRAMES(10),
      .ARR_FRAMES(3)
   ) dut (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .keycode    (keycode),
      .cmd_ack    (cmd_ack),
      .cmd_valid  (cmd_valid),
      .cmd_keycode(cmd_keycode)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic step;
      @(posedge frame_clk);
      #1;
   endtask

   task automatic apply_reset;
      Reset   = 1'b1;
      keycode = 8'h00;
      cmd_ack = 1'b0;
      step();
      step();
      Reset = 1'b0;
   endtask

   task automatic test_reset;
      Reset   = 1'b1;
      keycode = 8'h04;
      cmd_ack = 1'b0;
      step();
      tests_run++;
      if (cmd_valid !== 1'b0) begin
         $display("FAIL reset_valid: got %b expected 0", cmd_valid);
         tests_failed++;
      end
      tests_run++;
      if (cmd_keycode !== 8'h00) begin
         $display("FAIL reset_keycode: got %h expected 00", cmd_keycode);
         tests_failed++;
      end
      step();
      Reset = 1'b0;
      step();
      tests_run++;
      if (cmd_valid !== 1'b1 || cmd_keycode !== 8'h04) begin
         $display("FAIL reset_held_press: got valid=%b key=%h expected 1/04", cmd_valid, cmd_keycode);
         tests_failed++;
      end
   endtask

   task automatic test_das_arr;
      logic exp_v;
      apply_reset();
      cmd_ack = 1'b1;
      for (int e = 1; e <= 25; e++) begin
         keycode = (e >= 5) ? 8'h04 : 8'h00;
         step();
         exp_v = (e == 5 || e == 15 || e == 18 || e == 21 || e == 24);
         tests_run++;
         if (cmd_valid !== exp_v) begin
            $display("FAIL das_valid edge %0d: got %b expected %b", e, cmd_valid, exp_v);
            tests_failed++;
         end
         if (exp_v) begin
            tests_run++;
            if (cmd_keycode !== 8'h04) begin
               $display("FAIL das_keycode edge %0d: got %h expected 04", e, cmd_keycode);
               tests_failed++;
            end
         end
      end
   endtask

   task automatic test_rotate_one_shot;
      int n = 0;
      apply_reset();
      cmd_ack = 1'b1;
      keycode = 8'h1A;
      for (int i = 0; i < 40; i++) begin
         step();
         if (i == 0) begin
            tests_run++;
            if (cmd_valid !== 1'b1 || cmd_keycode !== 8'h1A) begin
               $display("FAIL rot_first: got valid=%b key=%h expected 1/1a", cmd_valid, cmd_keycode);
               tests_failed++;
            end
         end
         if (cmd_valid === 1'b1) n++;
      end
      tests_run++;
      if (n != 1) begin
         $display("FAIL rot_count: got %0d commands expected 1", n);
         tests_failed++;
      end
   endtask

   task automatic test_drop_no_ack;
      logic exp_v;
      apply_reset();
      keycode = 8'h16;
      for (int e = 0; e <= 11; e++) begin
         cmd_ack = (e == 7);
         step();
         exp_v = !(e == 7 || e == 8);
         tests_run++;
         if (cmd_valid !== exp_v || cmd_keycode !== 8'h16) begin
            $display("FAIL drop edge %0d: got valid=%b key=%h expected %b/16",
                     e, cmd_valid, cmd_keycode, exp_v);
            tests_failed++;
         end
      end
      cmd_ack = 1'b0;
   endtask

   task automatic test_key_switch;
      logic       exp_v;
      logic [7:0] exp_k;
      apply_reset();
      for (int e = 0; e <= 15; e++) begin
         keycode = (e < 4) ? 8'h04 : 8'h07;
         cmd_ack = (e == 5);
         step();
         exp_v = (e < 5) || (e >= 14);
         exp_k = (e < 4) ? 8'h04 : 8'h07;
         tests_run++;
         if (cmd_valid !== exp_v || cmd_keycode !== exp_k) begin
            $display("FAIL switch edge %0d: got valid=%b key=%h expected %b/%h",
                     e, cmd_valid, cmd_keycode, exp_v, exp_k);
            tests_failed++;
         end
      end
      cmd_ack = 1'b0;
   endtask

   task automatic test_ack_issue_same_edge;
      logic       exp_v;
      logic [7:0] exp_k;
      apply_reset();
      for (int e = 0; e <= 5; e++) begin
         keycode = (e < 5) ? 8'h16 : 8'h07;
         cmd_ack = (e >= 3);
         step();
         exp_v = (e != 4);
         exp_k = (e < 5) ? 8'h16 : 8'h07;
         tests_run++;
         if (cmd_valid !== exp_v || cmd_keycode !== exp_k) begin
            $display("FAIL ack_same_edge edge %0d: got valid=%b key=%h expected %b/%h",
                     e, cmd_valid, cmd_keycode, exp_v, exp_k);
            tests_failed++;
         end
      end
      cmd_ack = 1'b0;
   endtask

   task automatic test_reset_mid_hold;
      apply_reset();
      cmd_ack = 1'b1;
      keycode = 8'h07;
      for (int e = 0; e <= 12; e++) step();
      Reset = 1'b1;
      step();
      tests_run++;
      if (cmd_valid !== 1'b0 || cmd_keycode !== 8'h00) begin
         $display("FAIL mid_reset: got valid=%b key=%h expected 0/00", cmd_valid, cmd_keycode);
         tests_failed++;
      end
      Reset = 1'b0;
      step();
      tests_run++;
      if (cmd_valid !== 1'b1 || cmd_keycode !== 8'h07) begin
         $display("FAIL mid_reset_repress: got valid=%b key=%h expected 1/07", cmd_valid, cmd_keycode);
         tests_failed++;
      end
      for (int e = 15; e <= 24; e++) begin
         step();
         tests_run++;
         if (cmd_valid !== (e == 24)) begin
            $display("FAIL mid_reset_das edge %0d: got %b expected %b", e, cmd_valid, (e == 24));
            tests_failed++;
         end
      end
   endtask

   task automatic test_unrecognised;
      apply_reset();
      keycode = 8'h05;
      step();
      tests_run++;
      if (cmd_valid !== 1'b0) begin
         $display("FAIL unrec_ignored: got %b expected 0", cmd_valid);
         tests_failed++;
      end
      keycode = 8'h04;
      step();
      tests_run++;
      if (cmd_valid !== 1'b1 || cmd_keycode !== 8'h04) begin
         $display("FAIL unrec_press: got valid=%b key=%h expected 1/04", cmd_valid, cmd_keycode);
         tests_failed++;
      end
      keycode = 8'h05;
      cmd_ack = 1'b1;
      step();
      tests_run++;
      if (cmd_valid !== 1'b0 || cmd_keycode !== 8'h04) begin
         $display("FAIL unrec_release: got valid=%b key=%h expected 0/04", cmd_valid, cmd_keycode);
         tests_failed++;
      end
      keycode = 8'h04;
      cmd_ack = 1'b0;
      step();
      tests_run++;
      if (cmd_valid !== 1'b1) begin
         $display("FAIL unrec_repress: got %b expected 1", cmd_valid);
         tests_failed++;
      end
   endtask

   initial begin
      test_reset();
      test_das_arr();
      test_rotate_one_shot();
      test_drop_no_ack();
      test_key_switch();
      test_ack_issue_same_edge();
      test_reset_mid_hold();
      test_unrecognised();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/key_repeat_ctrl.md
# key_repeat_ctrl

Input-side conditioner that converts the raw held USB keycode into discrete move commands for the falling-piece game logic. It edge-detects key presses and applies delayed auto-shift (DAS) and auto-repeat (ARR) timing. It presents one pending command at a time through a valid/ack handshake. The game logic consumes it on its move tick.

## Interface
- DAS_FRAMES, 10: frames from initial press until the first auto-repeat (A/D only); legal range 1–255.
- ARR_FRAMES, 3: frames between auto-repeats; legal range 1–255.
- frame_clk  in  1  sole clock, one edge per video frame; all logic on posedge.
- Reset  in  1  synchronous, active-high; sampled on posedge frame_clk.
- keycode  in  8  raw keycode from USB host, level, held while the key is down; 8'h00 = none.
- cmd_ack  in  1  consumer accepted cmd_keycode on this edge.
- cmd_valid  out  1  a command is pending.
- cmd_keycode  out  8  pending command: 8'h04 left, 8'h07 right, 8'h16 soft drop, 8'h1A rotate.

## Operation
- Recognised keys: 04 (A), 07 (D), 16 (S), 1A (W). Any other value, including 00, is "no key".
- key_prev register holds the last sampled recognised key (00 if none).
- A new press is a recognised key != key_prev. A key-to-key change (04→07) counts as a new press.
- States and transitions:
  - IDLE: no key held. On a new press, issue a command, then:
    - A/D → DAS
    - S → REPEAT
    - W → HOLD
  - DAS: cnt increments each frame. When cnt == DAS_FRAMES-1, issue a command, clear cnt, go to REPEAT.
  - REPEAT: cnt increments each frame. When cnt == ARR_FRAMES-1, issue a command and clear cnt.
  - HOLD: no further commands; rotate is one-shot.
- Key release (no key) from any state → IDLE, cnt cleared. No command is issued on release.
- A new press from any state re-enters as from IDLE, with cnt cleared.
- Issuing rules:
  - A new-press command always loads cmd_keycode and sets cmd_valid, overwriting any pending command.
  - A repeat command is dropped if cmd_valid=1 and cmd_ack=0 on that edge. The repeat timer keeps running regardless.
- Ack handling:
  - cmd_ack with cmd_valid=1 clears cmd_valid.
  - cmd_ack with cmd_valid=0 is ignored.
  - cmd_ack and a command issue on the same edge: the issue wins; cmd_valid stays 1 with the new keycode.
- Counter: 8-bit unsigned. It is cleared on every state entry and never wraps, because the compare value is always ≤ 254.

## Timing
- Reset values: cmd_valid=0, cmd_keycode=8'h00, state=IDLE, cnt=0, key_prev=8'h00.
- Reset asserted mid-hold: outputs return to reset values on the next edge. A key still held when Reset drops counts as a new press on the first edge after release of Reset.
- Latency: a key first sampled at edge k produces cmd_valid=1 visible after edge k (one registered stage, no combinational input→output path).
- A/D held continuously from edge k: commands at k, k+DAS_FRAMES, then every ARR_FRAMES after that.
- S held from edge k: commands at k, k+ARR_FRAMES, k+2·ARR_FRAMES, …
- W held: a single command at k.
- cmd_keycode is stable whenever cmd_valid=1, unless overwritten by a new press.

## Structure
- Shared package key_cmd_pkg:
  - KEY_LEFT, KEY_RIGHT, KEY_DROP, KEY_ROT, KEY_NONE keycode constants.
  - The state enum (IDLE, DAS, REPEAT, HOLD).
  - The game logic imports the same keycode constants.
- Single flat module; no sub-module. Next-state logic and the command-issue decision are in one combinational block, registered in one always_ff.

## Test plan
- Reset, then keycode=04 at edge 5 with cmd_ack tied high → cmd_valid pulses after edges 5, 15, 18, 21 with cmd_keycode=04 each time.
- keycode=1A held 40 frames, cmd_ack high → exactly one command (1A) after the first edge; none after that.
- keycode=16 held, cmd_ack low throughout → cmd_valid=1 with 16 from the first edge onward. Repeats are dropped and no overwrite occurs. Raising ack at frame 7 clears valid; the next repeat at frame 9 sets it again.
- keycode 04 for 4 frames, then 07, with ack low → cmd_keycode changes 04→07 on the switch edge. The DAS counter restarts, so the first 07 repeat is 10 frames after the switch.
- ack and a repeat issue on the same edge → cmd_valid stays 1 and cmd_keycode holds the new command.
- Reset asserted while in REPEAT with 07 held → after the Reset edge cmd_valid=0 and cmd_keycode=00. The first edge after Reset falls issues 07.
